// File: rtl/v_first_idx_pkg.sv
// Shared vALU definitions: state encoding for the first-index scanner and
// the all-ones scalar result returned when no element is active and set.
package v_first_idx_pkg;

    localparam int VALU_RESP_W = 64;

    // Scalar result meaning "no element found" (-1 in two's complement).
    localparam logic [VALU_RESP_W-1:0] VALU_RESP_ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SKIP = 2'd2
    } vfi_state_e;

endpackage

// File: rtl/v_first_idx_prio_enc.sv
// Lowest-bit-wins priority encoder: reports whether any bit is set and the
// index of the lowest set bit. Purely combinational.
module v_prio_enc #(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int POS_W          = $clog2(REQ_DATA_WIDTH)
) (
    input  logic [REQ_DATA_WIDTH-1:0] in_bits,
    output logic                      hit,
    output logic [POS_W-1:0]          pos
);

    // Walk from the top down so the lowest set bit is the last (winning) write.
    always_comb begin
        hit = |in_bits;
        pos = '0;
        for (int i = REQ_DATA_WIDTH - 1; i >= 0; i--) begin
            if (in_bits[i]) begin
                pos = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/v_first_idx.sv
// vfirst.m: scans a multi-beat mask stream and returns the element index of
// the lowest set bit below vl, or all ones when there is none.
module v_first_idx
    import v_first_idx_pkg::*;
#(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH  = 5,
    parameter int VL_WIDTH        = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [REQ_DATA_WIDTH-1:0]  in_mask,
    input  logic                       in_last,
    input  logic [VL_WIDTH-1:0]        in_vl,
    input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
    output logic                       out_valid,
    output logic [REQ_ADDR_WIDTH-1:0]  out_addr,
    output logic [RESP_DATA_WIDTH-1:0] out_idx
);

    localparam int POS_W  = $clog2(REQ_DATA_WIDTH);
    localparam int BASE_W = VL_WIDTH + 1;
    // One extra bit so base+lane never overflows in the lane-enable compare.
    localparam int EW     = VL_WIDTH + 2;

    localparam logic [RESP_DATA_WIDTH-1:0] NONE_IDX =
        RESP_DATA_WIDTH'(VALU_RESP_ALL_ONES);
    localparam logic [BASE_W-1:0] BEAT_STEP = BASE_W'(REQ_DATA_WIDTH);

    vfi_state_e                 state_q,     state_d;
    logic [BASE_W-1:0]          base_q,      base_d;
    logic                       found_q,     found_d;
    logic [RESP_DATA_WIDTH-1:0] idx_reg_q,   idx_reg_d;
    logic [VL_WIDTH-1:0]        vl_reg_q,    vl_reg_d;
    logic [REQ_ADDR_WIDTH-1:0]  addr_reg_q,  addr_reg_d;
    logic                       out_valid_q, out_valid_d;
    logic [REQ_ADDR_WIDTH-1:0]  out_addr_q,  out_addr_d;
    logic [RESP_DATA_WIDTH-1:0] out_idx_q,   out_idx_d;

    logic                       first_beat;
    logic [VL_WIDTH-1:0]        cur_vl;
    logic [BASE_W-1:0]          cur_base;
    logic [REQ_DATA_WIDTH-1:0]  lane_en;
    logic [REQ_DATA_WIDTH-1:0]  eff;
    logic                       hit;
    logic [POS_W-1:0]           pos;
    logic [RESP_DATA_WIDTH-1:0] beat_idx;

    // Beat evaluation: the first beat uses the live vl and a zero base since
    // nothing has been latched yet; later beats use the latched context.
    always_comb begin
        first_beat = (state_q == IDLE);
        cur_vl     = first_beat ? in_vl : vl_reg_q;
        cur_base   = first_beat ? '0 : base_q;
        lane_en    = '0;
        for (int i = 0; i < REQ_DATA_WIDTH; i++) begin
            lane_en[i] = (EW'(cur_base) + EW'(i)) < EW'(cur_vl);
        end
        eff = in_mask & lane_en;
    end

    v_prio_enc #(
        .REQ_DATA_WIDTH (REQ_DATA_WIDTH),
        .POS_W          (POS_W)
    ) u_prio_enc (
        .in_bits (eff),
        .hit     (hit),
        .pos     (pos)
    );

    assign beat_idx = RESP_DATA_WIDTH'(cur_base) + RESP_DATA_WIDTH'(pos);

    // Next-state logic: base/hit tracking, FSM transitions and result strobe.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        found_d     = found_q;
        idx_reg_d   = idx_reg_q;
        vl_reg_d    = vl_reg_q;
        addr_reg_d  = addr_reg_q;
        out_valid_d = 1'b0;
        out_addr_d  = '0;
        out_idx_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vl_reg_d   = in_vl;
                    addr_reg_d = in_addr;
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        out_addr_d  = in_addr;
                        out_idx_d   = hit ? beat_idx : NONE_IDX;
                        base_d      = '0;
                        found_d     = 1'b0;
                    end else begin
                        base_d    = BEAT_STEP;
                        found_d   = hit;
                        idx_reg_d = hit ? beat_idx : '0;
                        state_d   = hit ? SKIP : SCAN;
                    end
                end
            end
            SCAN: begin
                if (in_valid) begin
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        out_addr_d  = addr_reg_q;
                        out_idx_d   = hit ? beat_idx : NONE_IDX;
                        base_d      = '0;
                        found_d     = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        base_d = base_q + BEAT_STEP;
                        if (hit) begin
                            found_d   = 1'b1;
                            idx_reg_d = beat_idx;
                            state_d   = SKIP;
                        end
                    end
                end
            end
            SKIP: begin
                // The first hit is already held; later mask content is moot.
                if (in_valid) begin
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        out_addr_d  = addr_reg_q;
                        out_idx_d   = found_q ? idx_reg_q : NONE_IDX;
                        base_d      = '0;
                        found_d     = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        base_d = base_q + BEAT_STEP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                base_d  = '0;
                found_d = 1'b0;
            end
        endcase
    end

    // State registers; reset also kills a result due out next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            found_q     <= 1'b0;
            idx_reg_q   <= '0;
            vl_reg_q    <= '0;
            addr_reg_q  <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            found_q     <= found_d;
            idx_reg_q   <= idx_reg_d;
            vl_reg_q    <= vl_reg_d;
            addr_reg_q  <= addr_reg_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_idx   = out_idx_q;

endmodule
